// File: rtl/csr_test_monitor.sv
// csr_test_monitor: sticky pass/fail/timeout verdict from tohost CSR writes; in clk,rst,csr_we,csr_addr,csr_wdata,instr_retire; out tohost,done,passed,timed_out,fail_id,cycle_count,instret_count
module csr_test_monitor #(
  parameter logic [11:0] TOHOST_ADDR = 12'h51E,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 csr_we,
  input  logic [11:0]          csr_addr,
  input  logic [31:0]          csr_wdata,
  input  logic                 instr_retire,
  output logic [31:0]          tohost,
  output logic                 done,
  output logic                 passed,
  output logic                 timed_out,
  output logic [30:0]          fail_id,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instret_count
);
  typedef enum logic [1:0] {RUN, PASS, FAIL, TIMEOUT} state_t;
  state_t r_state, w_next;
  logic w_run, w_hit, w_term, w_limit;
  logic [31:0] r_tohost;
  logic r_done, r_passed, r_timed_out;
  logic [30:0] r_fail_id;
  logic [CNT_WIDTH-1:0] r_cycle, r_instret;
  assign w_run = r_state == RUN;
  assign w_hit = csr_we && csr_addr == TOHOST_ADDR;
  assign w_term = w_hit && csr_wdata[0];
  assign w_limit = r_cycle == CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  always_comb begin
    w_next = r_state;
    if (w_run)
      w_next = w_term ? (|csr_wdata[31:1] ? FAIL : PASS) : (w_limit ? TIMEOUT : RUN);
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tohost    <= '0;
      r_done      <= 1'b0;
      r_passed    <= 1'b0;
      r_timed_out <= 1'b0;
      r_fail_id   <= '0;
      r_cycle     <= '0;
      r_instret   <= '0;
    end else if (w_run) begin
      r_cycle     <= r_cycle + CNT_WIDTH'(1);
      if (instr_retire && !(&r_instret)) r_instret <= r_instret + CNT_WIDTH'(1);
      if (w_hit) r_tohost <= csr_wdata;
      r_done      <= w_next != RUN;
      r_passed    <= w_next == PASS;
      r_timed_out <= w_next == TIMEOUT;
      if (w_next == FAIL) r_fail_id <= csr_wdata[31:1];
    end
  end
  assign tohost        = r_tohost;
  assign done          = r_done;
  assign passed        = r_passed;
  assign timed_out     = r_timed_out;
  assign fail_id       = r_fail_id;
  assign cycle_count   = r_cycle;
  assign instret_count = r_instret;
endmodule

// File: tb/tb_csr_test_monitor.sv
// tb_csr_test_monitor: directed and randomized checks of csr_test_monitor against a behavioural model
module tb_csr_test_monitor;
  logic clk = 1'b0;
  logic rst, csr_we, instr_retire;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, tohost;
  logic done, passed, timed_out;
  logic [30:0] fail_id;
  logic [31:0] cycle_count, instret_count;
  int n_tests = 0;
  int n_fail = 0;
  int m_cyc, m_ret;
  logic [31:0] m_tohost;
  logic m_done, m_passed, m_to;
  logic [30:0] m_fail;

  localparam int TO = 10;

  csr_test_monitor #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .instr_retire(instr_retire), .tohost(tohost), .done(done), .passed(passed),
    .timed_out(timed_out), .fail_id(fail_id), .cycle_count(cycle_count),
    .instret_count(instret_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csr_we = 1'b0;
    csr_addr = 12'h0;
    csr_wdata = 32'h0;
    instr_retire = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1'b1;
    csr_addr = a;
    csr_wdata = d;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({tohost, done, passed, timed_out, fail_id, cycle_count, instret_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: tohost=%h done=%b passed=%b to=%b fid=%h cyc=%0d ret=%0d, all required 0",
               tohost, done, passed, timed_out, fail_id, cycle_count, instret_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_pass();
    do_reset();
    repeat (5) tick();
    n_tests++;
    if (done !== 1'b0 || cycle_count !== 32'd5) begin
      n_fail++;
      $display("FAIL pass_pre: done=%b cyc=%0d, required done=0 cyc=5", done, cycle_count);
    end
    wr(12'h51E, 32'h1);
    n_tests++;
    if (done !== 1'b1 || passed !== 1'b1 || fail_id !== 31'd0 || tohost !== 32'h1 || cycle_count !== 32'd6) begin
      n_fail++;
      $display("FAIL pass_verdict: done=%b passed=%b fid=%0d tohost=%h cyc=%0d, required 1 1 0 1 6",
               done, passed, fail_id, tohost, cycle_count);
    end
    repeat (20) tick();
    n_tests++;
    if (done !== 1'b1 || passed !== 1'b1 || timed_out !== 1'b0 || tohost !== 32'h1 || cycle_count !== 32'd6) begin
      n_fail++;
      $display("FAIL pass_hold: done=%b passed=%b to=%b tohost=%h cyc=%0d, required 1 1 0 1 6",
               done, passed, timed_out, tohost, cycle_count);
    end
  endtask

  task automatic test_fail();
    do_reset();
    tick();
    wr(12'h51E, 32'h0000_000B);
    n_tests++;
    if (done !== 1'b1 || passed !== 1'b0 || fail_id !== 31'd5 || tohost !== 32'hB || timed_out !== 1'b0) begin
      n_fail++;
      $display("FAIL fail_verdict: done=%b passed=%b fid=%0d tohost=%h to=%b, required 1 0 5 b 0",
               done, passed, fail_id, tohost, timed_out);
    end
    wr(12'h51E, 32'h1);
    n_tests++;
    if (tohost !== 32'hB || passed !== 1'b0 || fail_id !== 31'd5 || cycle_count !== 32'd2) begin
      n_fail++;
      $display("FAIL fail_absorb: tohost=%h passed=%b fid=%0d cyc=%0d, required b 0 5 2",
               tohost, passed, fail_id, cycle_count);
    end
  endtask

  task automatic test_progress();
    do_reset();
    wr(12'h51E, 32'h4);
    wr(12'h300, 32'h1);
    n_tests++;
    if (done !== 1'b0 || tohost !== 32'h4) begin
      n_fail++;
      $display("FAIL progress: done=%b tohost=%h, required done=0 tohost=4", done, tohost);
    end
    wr(12'h51E, 32'h0);
    n_tests++;
    if (done !== 1'b0 || tohost !== 32'h0) begin
      n_fail++;
      $display("FAIL progress_zero: done=%b tohost=%h, required done=0 tohost=0", done, tohost);
    end
    wr(12'h51E, 32'h1);
    n_tests++;
    if (done !== 1'b1 || passed !== 1'b1 || cycle_count !== 32'd4) begin
      n_fail++;
      $display("FAIL progress_pass: done=%b passed=%b cyc=%0d, required 1 1 4", done, passed, cycle_count);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (TO - 1) tick();
    n_tests++;
    if (done !== 1'b0 || timed_out !== 1'b0 || cycle_count !== 32'(TO - 1)) begin
      n_fail++;
      $display("FAIL timeout_early: done=%b to=%b cyc=%0d, required 0 0 %0d", done, timed_out, cycle_count, TO - 1);
    end
    tick();
    n_tests++;
    if (done !== 1'b1 || timed_out !== 1'b1 || passed !== 1'b0 || cycle_count !== 32'(TO)) begin
      n_fail++;
      $display("FAIL timeout_hit: done=%b to=%b passed=%b cyc=%0d, required 1 1 0 %0d",
               done, timed_out, passed, cycle_count, TO);
    end
    instr_retire = 1'b1;
    repeat (5) tick();
    wr(12'h51E, 32'h1);
    n_tests++;
    if (cycle_count !== 32'(TO) || instret_count !== 32'd0 || passed !== 1'b0 || tohost !== 32'h0) begin
      n_fail++;
      $display("FAIL timeout_freeze: cyc=%0d ret=%0d passed=%b tohost=%h, required %0d 0 0 0",
               cycle_count, instret_count, passed, tohost, TO);
    end
  endtask

  task automatic test_hit_vs_timeout();
    do_reset();
    repeat (TO - 1) tick();
    wr(12'h51E, 32'h1);
    n_tests++;
    if (passed !== 1'b1 || timed_out !== 1'b0 || done !== 1'b1 || cycle_count !== 32'(TO)) begin
      n_fail++;
      $display("FAIL hit_wins: passed=%b to=%b done=%b cyc=%0d, required 1 0 1 %0d",
               passed, timed_out, done, cycle_count, TO);
    end
  endtask

  task automatic test_instret();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      instr_retire = i[0];
      tick();
    end
    instr_retire = 1'b1;
    wr(12'h51E, 32'h1);
    n_tests++;
    if (instret_count !== 32'd5 || passed !== 1'b1 || cycle_count !== 32'd9) begin
      n_fail++;
      $display("FAIL instret: ret=%0d passed=%b cyc=%0d, required 5 1 9", instret_count, passed, cycle_count);
    end
    do_reset();
    instr_retire = 1'b1;
    repeat (3) tick();
    wr(12'h51E, 32'h6);
    rst = 1'b1;
    instr_retire = 1'b1;
    tick();
    rst = 1'b0;
    instr_retire = 1'b0;
    n_tests++;
    if ({tohost, done, passed, timed_out, fail_id, cycle_count, instret_count} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: tohost=%h done=%b cyc=%0d ret=%0d, all required 0",
               tohost, done, cycle_count, instret_count);
    end
    tick();
    n_tests++;
    if (cycle_count !== 32'd1 || instret_count !== 32'd0) begin
      n_fail++;
      $display("FAIL restart: cyc=%0d ret=%0d, required 1 0", cycle_count, instret_count);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_cyc = 0; m_ret = 0; m_tohost = 0; m_done = 0; m_passed = 0; m_to = 0; m_fail = 0;
    end else if (!m_done) begin
      m_cyc++;
      if (instr_retire) m_ret++;
      if (csr_we && csr_addr == 12'h51E) begin
        m_tohost = csr_wdata;
        if (csr_wdata[0]) begin
          m_done = 1;
          if (csr_wdata[31:1] == 0) m_passed = 1;
          else m_fail = csr_wdata[31:1];
        end
      end
      if (!m_done && m_cyc == TO) begin
        m_done = 1;
        m_to = 1;
      end
    end
  endtask

  task automatic test_random();
    int r;
    rst = 1'b1;
    idle();
    model_step();
    tick();
    for (int i = 0; i < 600; i++) begin
      rst = $urandom_range(0, 29) == 0;
      csr_we = $urandom_range(0, 2) == 0;
      csr_addr = $urandom_range(0, 3) == 0 ? 12'($urandom) : 12'h51E;
      r = $urandom_range(0, 5);
      csr_wdata = r == 0 ? 32'h1 : r == 1 ? ($urandom | 32'h1) : r == 2 ? 32'h0 : ($urandom & ~32'h1);
      instr_retire = $urandom_range(0, 1) == 1;
      model_step();
      tick();
      n_tests++;
      if (tohost !== m_tohost || done !== m_done || passed !== m_passed || timed_out !== m_to ||
          fail_id !== m_fail || cycle_count !== 32'(m_cyc) || instret_count !== 32'(m_ret)) begin
        n_fail++;
        $display("FAIL random[%0d]: got tohost=%h done=%b passed=%b to=%b fid=%h cyc=%0d ret=%0d; required %h %b %b %b %h %0d %0d",
                 i, tohost, done, passed, timed_out, fail_id, cycle_count, instret_count,
                 m_tohost, m_done, m_passed, m_to, m_fail, m_cyc, m_ret);
      end
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_pass();
    test_fail();
    test_progress();
    test_timeout();
    test_hit_vs_timeout();
    test_instret();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
